executing_hilo_stage: RTL and testbench
=======================================

// Module: executing_hilo_stage
// PURPOSE
// - Registered MIPS execute stage: operand mux, ALU and destination-register mux, plus an
//   iterative multiply/divide unit with architectural HI/LO registers.
// - Sits between the decode/register-read stage and memory; drives the EX/MEM register.
// - Parametrised in data width; mult/div run in the background; interlocks only on HI/LO use.
// PARAMETERS
// - WIDTH       32  datapath width; mult/div take WIDTH iteration cycles
// - REG_ADDR_W  5   register-file address width
// PORTS
// clk                in   1           rising-edge clock
// reset              in   1           asynchronous, active-low reset
// inValid            in   1           decode presents a valid instruction
// stallIn            in   1           downstream stall; freeze output register
// aluSrc             in   1           1: operand B = immediateExtended; 0: readRegister1
// regDst             in   1           1: dest = addressRegisterRd; 0: addressRegisterRt
// aluOp              in   4           0:add 1:sub 2:R-type(use func) 3:and 4:or 5:slt 6:lui
// func               in   6           R-type function field
// readRegister0      in   WIDTH       operand A
// readRegister1      in   WIDTH       register operand B
// immediateExtended  in   WIDTH       sign-extended immediate
// addressRegisterRt  in   REG_ADDR_W  rt field
// addressRegisterRd  in   REG_ADDR_W  rd field
// stallOut           out  1           instruction not accepted this cycle; hold decode
// outValid           out  1           EX/MEM register holds a result to write back
// resultAluOutput    out  WIDTH       registered result
// isAluOutputZero    out  1           registered (result == 0)
// addressRegWrite    out  REG_ADDR_W  registered destination register
// mulDivBusy         out  1           iterative unit active
// overflowTrap       out  1           registered signed add/sub overflow (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, HI=LO=0, FSM IDLE. Reset mid-operation aborts and discards mult/div.
// - Accept = inValid & ~stallOut. stallOut = stallIn | (mulDivBusy & HI/LO-class op).
//   HI/LO-class ops: func 0x18-0x1B, 0x10-0x13.
// - R-type funcs: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor,
//   0x2A slt (signed), 0x2B sltu, 0x10 mfhi, 0x12 mflo, 0x11 mthi, 0x13 mtlo,
//   0x18 mult, 0x19 multu, 0x1A div, 0x1B divu. Any other func: result 0.
// - lui: result = operand B << 16. Arithmetic is modulo 2^WIDTH.
// - Output register: on accept of a non-mult/div, non-mthi/mtlo op, it loads result,
//   zero flag and destination at the next edge, and outValid=1 the following cycle.
//   mult/div/mthi/mtlo: outValid=0 (no register write).
//   No accept and ~stallIn: outValid=0. stallIn=1: all outputs hold.
// - mthi/mtlo: HI/LO <= readRegister0 at the accept edge.
// - FSM IDLE -> MUL|DIV on an accepted mult/div. mulDivBusy=1 for exactly WIDTH cycles from
//   the next cycle. HI/LO are written on the final busy edge; IDLE the cycle after.
// - MUL: shift-add over magnitudes; 2*WIDTH product; HI = upper, LO = lower half.
//   Signed: negate the product if the operand signs differ.
// - DIV: restoring; LO = quotient, HI = remainder. Signed: quotient negative if signs differ;
//   remainder takes dividend sign. Div-by-0: LO = all ones, HI = dividend (unsigned magnitude
//   path, sign fix still applied). Signed MIN/-1: LO = MIN, HI = 0.
// - Non-HI/LO ops issue and retire normally while busy; mfhi after mult stalls until IDLE,
//   then reads the new HI.
// - An accepted mult while busy is impossible (it stalls); stallIn during busy does not pause the FSM.
// CONFIGURATION
// - EXEC_OVERFLOW_TRAP_EN defined: signed add (0x20, aluOp 0) / sub (0x22, aluOp 1) overflow
//   sets overflowTrap=1 alongside the registered beat, outValid=0 (no writeback).
//   addu/subu never trap.
// - Undefined: overflowTrap tied 0; overflowing add/sub wraps and writes back normally.
// TESTING
// - add: r0=7, r1=5, aluOp=2, func=0x20, regDst=1, rd=9 -> next cycle outValid=1,
//   result=12, addr=9, zero=0.
// - mult: 0xFFFFFFFF x 2 -> busy for 32 cycles; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFFE;
//   multu gives HI=1, LO=0xFFFFFFFE.
// - div: -7/2 signed -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> LO=0xFFFFFFFF, HI=7.
// - Interlock: mult, then add, then mflo -> add retires while busy; mflo holds stallOut=1
//   until IDLE, then returns the product.
// - stallIn=1 for 3 cycles with a valid output -> outputs frozen; reset low during busy ->
//   all outputs 0, HI=LO=0, mulDivBusy=0 immediately.
// - With EXEC_OVERFLOW_TRAP_EN: 0x7FFFFFFF + 1 (func 0x20) -> overflowTrap=1, outValid=0;
//   func 0x21 -> result 0x80000000, outValid=1.

Source files
------------

// File: rtl/executing_hilo_stage.sv
// -----------------------------------------------------------------------------
// executing_hilo_stage
//
// Registered MIPS execute stage. It contains the operand mux, the ALU, the
// destination-register mux and the EX/MEM output register. It also contains an
// iterative multiply/divide unit that owns the architectural HI/LO registers.
// Mult/div runs in the background. Only HI/LO-class instructions interlock
// while that unit is busy.
//
// Parameters
//   WIDTH       datapath width; mult/div take WIDTH iteration cycles
//   REG_ADDR_W  register-file address width
//
// Ports
//   clk                rising-edge clock
//   reset              asynchronous, active-low reset
//   inValid            decode presents a valid instruction
//   stallIn            downstream stall; output register holds
//   aluSrc             1: operand B = immediateExtended, 0: readRegister1
//   regDst             1: dest = addressRegisterRd, 0: addressRegisterRt
//   aluOp              0 add, 1 sub, 2 R-type (func), 3 and, 4 or, 5 slt, 6 lui
//   func               R-type function field
//   readRegister0      operand A
//   readRegister1      register operand B
//   immediateExtended  sign-extended immediate
//   addressRegisterRt  rt field
//   addressRegisterRd  rd field
//   stallOut           instruction not accepted this cycle; decode must hold
//   outValid           EX/MEM register holds a result to write back
//   resultAluOutput    registered result
//   isAluOutputZero    registered (result == 0)
//   addressRegWrite    registered destination register
//   mulDivBusy         iterative unit active
//   overflowTrap       registered signed add/sub overflow
//
// Configuration
//   EXEC_OVERFLOW_TRAP_EN  When this macro is defined, a signed add or sub that
//                          overflows raises overflowTrap and suppresses the
//                          writeback. When it is undefined, overflowTrap stays 0
//                          and the result wraps.
// -----------------------------------------------------------------------------
module executing_hilo_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inValid,
  input  logic                  stallIn,
  input  logic                  aluSrc,
  input  logic                  regDst,
  input  logic [3:0]            aluOp,
  input  logic [5:0]            func,
  input  logic [WIDTH-1:0]      readRegister0,
  input  logic [WIDTH-1:0]      readRegister1,
  input  logic [WIDTH-1:0]      immediateExtended,
  input  logic [REG_ADDR_W-1:0] addressRegisterRt,
  input  logic [REG_ADDR_W-1:0] addressRegisterRd,
  output logic                  stallOut,
  output logic                  outValid,
  output logic [WIDTH-1:0]      resultAluOutput,
  output logic                  isAluOutputZero,
  output logic [REG_ADDR_W-1:0] addressRegWrite,
  output logic                  mulDivBusy,
  output logic                  overflowTrap
);

  // aluOp encodings
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_RTY = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_LUI = 4'd6;

  // R-type function codes
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  out_valid_q,     out_valid_d;
  logic [WIDTH-1:0]      result_q,        result_d;
  logic                  zero_q,          zero_d;
  logic [REG_ADDR_W-1:0] addr_q,          addr_d;
  logic                  overflow_trap_q, overflow_trap_d;
  logic [WIDTH-1:0]      hi_q,            hi_d;
  logic [WIDTH-1:0]      lo_q,            lo_d;
  md_state_e             state_q,         state_d;
  logic [CNT_W-1:0]      count_q,         count_d;
  // During a multiply, acc holds {partial product, remaining multiplier bits}.
  // During a divide, acc holds {partial remainder, remaining dividend / quotient}.
  logic [2*WIDTH-1:0]    acc_q,           acc_d;
  logic [WIDTH-1:0]      opnd_q,          opnd_d;   // multiplicand or divisor magnitude
  logic                  neg_q,           neg_d;    // negate product / quotient
  logic                  rem_neg_q,       rem_neg_d;

  // ---------------------------------------------------------------------------
  // Decode, interlock and operand selection
  // ---------------------------------------------------------------------------
  logic                  is_rtype;
  logic                  is_muldiv;
  logic                  is_hilo_class;
  logic                  is_mthi;
  logic                  is_mtlo;
  logic                  writes_reg;
  logic                  accept;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic [REG_ADDR_W-1:0] dest_addr;

  assign is_rtype      = (aluOp == ALU_RTY);
  assign is_muldiv     = is_rtype && (func inside {[F_MULT:F_DIVU]});
  assign is_hilo_class = is_rtype && (func inside {[F_MFHI:F_MTLO], [F_MULT:F_DIVU]});
  assign is_mthi       = is_rtype && (func == F_MTHI);
  assign is_mtlo       = is_rtype && (func == F_MTLO);
  assign writes_reg    = !(is_muldiv || is_mthi || is_mtlo);

  assign mulDivBusy = (state_q != ST_IDLE);
  assign stallOut   = stallIn | (mulDivBusy & is_hilo_class);
  assign accept     = inValid & ~stallOut;

  assign op_a      = readRegister0;
  assign op_b      = aluSrc ? immediateExtended : readRegister1;
  assign dest_addr = regDst ? addressRegisterRd : addressRegisterRt;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt_s;
  logic             slt_u;
  logic [WIDTH-1:0] alu_result;
  logic             trap_hit;

  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;
  assign slt_s = $signed(op_a) < $signed(op_b);
  assign slt_u = op_a < op_b;

  always_comb begin
    // NOTE: a default value before the case keeps every path assigned, so no latch is inferred.
    alu_result = '0;
    case (aluOp)
      ALU_ADD: alu_result = sum;
      ALU_SUB: alu_result = diff;
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_LUI: alu_result = op_b << 16;
      ALU_RTY: begin
        case (func)
          F_ADD, F_ADDU: alu_result = sum;
          F_SUB, F_SUBU: alu_result = diff;
          F_AND:         alu_result = op_a & op_b;
          F_OR:          alu_result = op_a | op_b;
          F_XOR:         alu_result = op_a ^ op_b;
          F_NOR:         alu_result = ~(op_a | op_b);
          F_SLT:         alu_result = {{(WIDTH-1){1'b0}}, slt_s};
          F_SLTU:        alu_result = {{(WIDTH-1){1'b0}}, slt_u};
          F_MFHI:        alu_result = hi_q;
          F_MFLO:        alu_result = lo_q;
          default:       alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

`ifdef EXEC_OVERFLOW_TRAP_EN
  // Only the signed forms trap. addu and subu always wrap.
  logic is_signed_add;
  logic is_signed_sub;
  logic add_ovf;
  logic sub_ovf;

  assign is_signed_add = (aluOp == ALU_ADD) || (is_rtype && (func == F_ADD));
  assign is_signed_sub = (aluOp == ALU_SUB) || (is_rtype && (func == F_SUB));
  assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != op_a[WIDTH-1]);
  assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
  assign trap_hit = (is_signed_add && add_ovf) || (is_signed_sub && sub_ovf);
`else
  assign trap_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // EX/MEM output register
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d     = out_valid_q;
    result_d        = result_q;
    zero_d          = zero_q;
    addr_d          = addr_q;
    overflow_trap_d = overflow_trap_q;
    // While stallIn is high the whole register holds, including the valid bit.
    if (!stallIn) begin
      out_valid_d     = 1'b0;
      overflow_trap_d = 1'b0;
      if (accept && writes_reg) begin
        result_d        = alu_result;
        zero_d          = (alu_result == '0);
        addr_d          = dest_addr;
        out_valid_d     = ~trap_hit;
        overflow_trap_d = trap_hit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply / divide unit
  // ---------------------------------------------------------------------------
  logic               md_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] product_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic               last_iter;

  // mult and div are signed. multu and divu (odd func codes) are unsigned.
  assign md_signed = ~func[0];
  assign mag_a = (md_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (md_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  // One shift-add step: optionally add the multiplicand to the upper half,
  // then shift the whole accumulator right by one.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // One restoring-division step. Shift the next dividend bit into the
  // remainder, and subtract the divisor when it fits. A zero divisor always
  // fits, so the quotient becomes all ones and the remainder becomes the
  // dividend magnitude.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});

  always_comb begin
    acc_step = acc_q;
    if (state_q == ST_MUL) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (state_q == ST_DIV) begin
      acc_step = {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge};
    end
  end

  assign product_fixed = neg_q     ? -acc_step : acc_step;
  assign quo_fixed     = neg_q     ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign rem_fixed     = rem_neg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  assign last_iter     = (count_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        // HI/LO-class ops stall while the unit is busy. So mthi, mtlo and the
        // start of a new op are only ever accepted here.
        if (accept && is_mthi) hi_d = op_a;
        if (accept && is_mtlo) lo_d = op_a;
        if (accept && is_muldiv) begin
          state_d   = func[1] ? ST_DIV : ST_MUL;
          count_d   = '0;
          acc_d     = {{WIDTH{1'b0}}, mag_a};
          opnd_d    = mag_b;
          neg_d     = md_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          rem_neg_d = md_signed & op_a[WIDTH-1];
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d   = acc_step;
        count_d = count_q + CNT_W'(1);
        if (last_iter) begin
          state_d = ST_IDLE;
          if (state_q == ST_MUL) begin
            hi_d = product_fixed[2*WIDTH-1:WIDTH];
            lo_d = product_fixed[WIDTH-1:0];
          end else begin
            hi_d = rem_fixed;
            lo_d = quo_fixed;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: HI/LO are architectural state and must read 0 after reset, so they
      // are reset with everything else. A reset also aborts any mult/div in flight.
      out_valid_q     <= 1'b0;
      result_q        <= '0;
      zero_q          <= 1'b0;
      addr_q          <= '0;
      overflow_trap_q <= 1'b0;
      hi_q            <= '0;
      lo_q            <= '0;
      state_q         <= ST_IDLE;
      count_q         <= '0;
      acc_q           <= '0;
      opnd_q          <= '0;
      neg_q           <= 1'b0;
      rem_neg_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values.
      out_valid_q     <= out_valid_d;
      result_q        <= result_d;
      zero_q          <= zero_d;
      addr_q          <= addr_d;
      overflow_trap_q <= overflow_trap_d;
      hi_q            <= hi_d;
      lo_q            <= lo_d;
      state_q         <= state_d;
      count_q         <= count_d;
      acc_q           <= acc_d;
      opnd_q          <= opnd_d;
      neg_q           <= neg_d;
      rem_neg_q       <= rem_neg_d;
    end
  end

  assign outValid        = out_valid_q;
  assign resultAluOutput = result_q;
  assign isAluOutputZero = zero_q;
  assign addressRegWrite = addr_q;
  assign overflowTrap    = overflow_trap_q;

endmodule

// File: tb/tb_executing_hilo_stage.sv
// -----------------------------------------------------------------------------
// tb_executing_hilo_stage
//
// Directed-vector scoreboard bench for executing_hilo_stage with WIDTH=32.
// The stimulus process pushes the expected EX/MEM beat when an instruction is
// accepted. A separate monitor pops and compares each new beat on the falling
// edge. Direct checks cover reset, interlock timing, stall hold and mid-op reset.
// -----------------------------------------------------------------------------
module tb_executing_hilo_stage;

  localparam int W = 32;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         stall_in;
  logic         alu_src;
  logic         reg_dst;
  logic [3:0]   alu_op;
  logic [5:0]   func;
  logic [W-1:0] r0;
  logic [W-1:0] r1;
  logic [W-1:0] imm;
  logic [A-1:0] rt;
  logic [A-1:0] rd;
  logic         stall_out;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic [A-1:0] addr;
  logic         busy;
  logic         overflow_trap;

  executing_hilo_stage #(.WIDTH(W), .REG_ADDR_W(A)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .inValid           (in_valid),
    .stallIn           (stall_in),
    .aluSrc            (alu_src),
    .regDst            (reg_dst),
    .aluOp             (alu_op),
    .func              (func),
    .readRegister0     (r0),
    .readRegister1     (r1),
    .immediateExtended (imm),
    .addressRegisterRt (rt),
    .addressRegisterRd (rd),
    .stallOut          (stall_out),
    .outValid          (out_valid),
    .resultAluOutput   (result),
    .isAluOutputZero   (zero),
    .addressRegWrite   (addr),
    .mulDivBusy        (busy),
    .overflowTrap      (overflow_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    bit           valid;
    bit           trap;
    logic [W-1:0] res;
    logic [A-1:0] addr;
    bit           zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [W-1:0] res, input logic [A-1:0] a);
    exp_t e;
    e.tag   = tag;
    e.valid = 1'b1;
    e.trap  = 1'b0;
    e.res   = res;
    e.addr  = a;
    e.zero  = (res == '0);
    return e;
  endfunction

  // Monitor. A beat is new when the output register could load at the previous
  // edge, i.e. stallIn was low for that edge.
  initial begin
    bit   prev_stall;
    exp_t e;
    prev_stall = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && (out_valid || overflow_trap) && !prev_stall) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got result 0x%08h addr %0d, expected no beat", result, addr);
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_valid"}, W'(out_valid), W'(e.valid));
          check({e.tag, "_trap"}, W'(overflow_trap), W'(e.trap));
          if (e.valid) begin
            check({e.tag, "_res"}, result, e.res);
            check({e.tag, "_addr"}, W'(addr), W'(e.addr));
            check({e.tag, "_zero"}, W'(zero), W'(e.zero));
          end
        end
      end
      prev_stall = stall_in;
    end
  end

  // Every task starts and returns just after a rising edge.
  task automatic issue(input logic [3:0] op, input logic [5:0] fn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit use_imm, input logic [A-1:0] dst,
                       input bit has_beat, input exp_t e, output int waited);
    alu_op  = op;
    func    = fn;
    r0      = a;
    alu_src = use_imm;
    if (use_imm) begin
      imm = b;
      r1  = 32'hDEAD_BEEF;
    end else begin
      r1  = b;
      imm = 32'hDEAD_BEEF;
    end
    reg_dst = (op == 4'd2);
    if (reg_dst) begin
      rd = dst;
      rt = ~dst;
    end else begin
      rt = dst;
      rd = ~dst;
    end
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (stall_out && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (stall_out) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got stallOut=1 after %0d cycles, expected acceptance", waited);
    end else if (has_beat) begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rop(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [A-1:0] dst, input logic [W-1:0] res,
                     output int waited);
    issue(4'd2, fn, a, b, 1'b0, dst, 1'b1, mk(tag, res, dst), waited);
  endtask

  task automatic iop(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [A-1:0] dst, input logic [W-1:0] res);
    int w;
    issue(op, 6'h00, a, b, 1'b1, dst, 1'b1, mk(tag, res, dst), w);
  endtask

  task automatic hop(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    int w;
    issue(4'd2, fn, a, b, 1'b0, 5'd0, 1'b0, mk("none", '0, 5'd0), w);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    int   n;
    exp_t e;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    stall_in = 1'b0;
    alu_src  = 1'b0;
    reg_dst  = 1'b0;
    alu_op   = 4'd0;
    func     = 6'd0;
    r0       = '0;
    r1       = '0;
    imm      = '0;
    rt       = '0;
    rd       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", W'(out_valid), 0);
    check("rst_result", result, 0);
    check("rst_addr", W'(addr), 0);
    check("rst_zero", W'(zero), 0);
    check("rst_busy", W'(busy), 0);
    check("rst_stallout", W'(stall_out), 0);
    check("rst_trap", W'(overflow_trap), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain ALU operations
    rop("add", 6'h20, 32'd7, 32'd5, 5'd9, 32'd12, w);
    iop("subi_zero", 4'd1, 32'd5, 32'd5, 5'd3, 32'd0);
    iop("andi", 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 5'd4, 32'h0000_F000);
    iop("ori", 4'd4, 32'h0000_00F0, 32'h0000_000F, 5'd5, 32'h0000_00FF);
    iop("slti", 4'd5, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd1);
    rop("sltu", 6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd0, w);
    rop("slt", 6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd1, w);
    iop("lui", 4'd6, 32'h0000_0055, 32'h0000_1234, 5'd10, 32'h1234_0000);
    rop("xor", 6'h26, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd11, 32'hF00F_F00F, w);
    rop("nor", 6'h27, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd12, 32'h00F0_00F0, w);
    rop("subu", 6'h23, 32'd3, 32'd5, 5'd13, 32'hFFFF_FFFE, w);
    rop("bad_func", 6'h3F, 32'd3, 32'd5, 5'd14, 32'd0, w);
    iop("addi_neg", 4'd0, 32'h0000_0010, 32'hFFFF_FFFF, 5'd15, 32'h0000_000F);

    // mthi / mtlo round trip
    hop(6'h11, 32'hAAAA_5555, 32'd0);
    hop(6'h13, 32'h1234_5678, 32'd0);
    rop("mfhi_mt", 6'h10, 32'd0, 32'd0, 5'd16, 32'hAAAA_5555, w);
    rop("mflo_mt", 6'h12, 32'd0, 32'd0, 5'd17, 32'h1234_5678, w);

    // Signed mult: -1 * 2
    hop(6'h18, 32'hFFFF_FFFF, 32'd2);
    check("mult_busy_start", W'(busy), 1);
    wait_idle(n);
    check("mult_busy_cycles", W'(n), 32);
    rop("mult_hi", 6'h10, 32'd0, 32'd0, 5'd18, 32'hFFFF_FFFF, w);
    rop("mult_lo", 6'h12, 32'd0, 32'd0, 5'd19, 32'hFFFF_FFFE, w);

    // multu, then an add that retires while busy, then an interlocked mflo
    hop(6'h19, 32'hFFFF_FFFF, 32'd2);
    rop("add_busy", 6'h21, 32'd40, 32'd2, 5'd20, 32'd42, w);
    check("busy_after_add", W'(busy), 1);
    rop("multu_lo", 6'h12, 32'd0, 32'd0, 5'd21, 32'hFFFF_FFFE, w);
    check("mflo_stall_cycles", W'(w), 31);
    rop("multu_hi", 6'h10, 32'd0, 32'd0, 5'd22, 32'h0000_0001, w);

    // Signed div -7 / 2
    hop(6'h1A, 32'hFFFF_FFF9, 32'd2);
    rop("div_lo", 6'h12, 32'd0, 32'd0, 5'd23, 32'hFFFF_FFFD, w);
    rop("div_hi", 6'h10, 32'd0, 32'd0, 5'd24, 32'hFFFF_FFFF, w);

    // divu 7 / 0
    hop(6'h1B, 32'd7, 32'd0);
    rop("divu0_lo", 6'h12, 32'd0, 32'd0, 5'd25, 32'hFFFF_FFFF, w);
    rop("divu0_hi", 6'h10, 32'd0, 32'd0, 5'd26, 32'd7, w);

    // Signed MIN / -1
    hop(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    rop("divmin_lo", 6'h12, 32'd0, 32'd0, 5'd27, 32'h8000_0000, w);
    rop("divmin_hi", 6'h10, 32'd0, 32'd0, 5'd28, 32'd0, w);

    // stallIn holds a valid output for three cycles, even with a new valid input
    rop("stall_add", 6'h21, 32'd100, 32'd23, 5'd6, 32'd123, w);
    stall_in = 1'b1;
    in_valid = 1'b1;
    alu_op   = 4'd2;
    func     = 6'h20;
    r0       = 32'd1;
    r1       = 32'd1;
    alu_src  = 1'b0;
    reg_dst  = 1'b1;
    rd       = 5'd7;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("frozen_valid", W'(out_valid), 1);
      check("frozen_result", result, 32'd123);
      check("frozen_addr", W'(addr), 32'd6);
      check("frozen_stallout", W'(stall_out), 1);
    end
    stall_in = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("valid_drop", W'(out_valid), 0);

    // Signed add overflow and the non-trapping addu
`ifdef EXEC_OVERFLOW_TRAP_EN
    e       = mk("add_ovf_trap", 32'h8000_0000, 5'd29);
    e.valid = 1'b0;
    e.trap  = 1'b1;
    issue(4'd2, 6'h20, 32'h7FFF_FFFF, 32'd1, 1'b0, 5'd29, 1'b1, e, w);
`else
    rop("add_ovf_wrap", 6'h20, 32'h7FFF_FFFF, 32'd1, 5'd29, 32'h8000_0000, w);
`endif
    rop("addu_ovf", 6'h21, 32'h7FFF_FFFF, 32'd1, 5'd30, 32'h8000_0000, w);

    // Reset while a multu is running and a valid result is held
    hop(6'h19, 32'd5, 32'd3);
    rop("add_pre_rst", 6'h21, 32'd1, 32'd1, 5'd2, 32'd2, w);
    @(negedge clk);
    #1;
    check("busy_pre_rst", W'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", W'(out_valid), 0);
    check("midrst_result", result, 0);
    check("midrst_addr", W'(addr), 0);
    check("midrst_busy", W'(busy), 0);
    check("midrst_trap", W'(overflow_trap), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rop("rst_hi", 6'h10, 32'd0, 32'd0, 5'd1, 32'd0, w);
    check("rst_hi_no_stall", W'(w), 0);
    rop("rst_lo", 6'h12, 32'd0, 32'd0, 5'd3, 32'd0, w);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", W'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
